// File: rtl/cpa_share_arb_pkg.sv
// ============================================================================
// Module      : cpa_pkg
// Description : Shared types and helpers for the shared-CPA arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpa_pkg;

    localparam int CPA_WIDTH = 32;
    localparam int MAX_NREQ  = 8;
    localparam int MAX_IDW   = $clog2(MAX_NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // First set bit at or after ptr, wrapping modulo nreq; -1 when none set.
    function automatic int rr_pick(input logic [MAX_NREQ-1:0] req,
                                   input int ptr,
                                   input int nreq);
        int                 pick;
        int                 idx;
        logic [MAX_IDW-1:0] sel;
        pick = -1;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = ptr + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                sel = MAX_IDW'(idx);
                if (req[sel]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpa_share_arb_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker starting the search at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import cpa_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [MAX_NREQ-1:0] w_req_ext;
    int                  w_pick;

    always_comb begin
        w_req_ext             = '0;
        w_req_ext[NREQ-1:0]   = req;
        w_pick                = rr_pick(w_req_ext, int'(ptr), NREQ);
        any                   = (w_pick >= 0);
        gnt_onehot            = '0;
        gnt_id                = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == i) begin
                gnt_onehot[i] = 1'b1;
                gnt_id        = IDW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpa_share_arb.sv
// ============================================================================
// Module      : cpa_share_arb
// Description : Round-robin sequencer time-sharing one external 32-bit CPA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpa_share_arb
    import cpa_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = CPA_WIDTH,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      cpa_x,
    output logic [WIDTH-1:0]      cpa_y,
    input  logic [WIDTH-1:0]      cpa_sum,
    input  logic                  cpa_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);

    state_t             r_state_q,    w_state_d;
    logic [IDW-1:0]     r_rr_ptr_q,   w_rr_ptr_d;
    logic [IDW-1:0]     r_grant_id_q, w_grant_id_d;
    logic [WIDTH-1:0]   r_cpa_x_q,    w_cpa_x_d;
    logic [WIDTH-1:0]   r_cpa_y_q,    w_cpa_y_d;
    logic               r_rsp_valid_q, w_rsp_valid_d;
    logic [IDW-1:0]     r_rsp_id_q,   w_rsp_id_d;
    logic [WIDTH-1:0]   r_rsp_sum_q,  w_rsp_sum_d;
    logic               r_rsp_cout_q, w_rsp_cout_d;

    logic [NREQ-1:0]    w_gnt_onehot;
    logic [IDW-1:0]     w_gnt_id;
    logic               w_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req        (req_valid),
        .ptr        (r_rr_ptr_q),
        .gnt_onehot (w_gnt_onehot),
        .gnt_id     (w_gnt_id),
        .any        (w_any)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_rr_ptr_d    = r_rr_ptr_q;
        w_grant_id_d  = r_grant_id_q;
        w_cpa_x_d     = r_cpa_x_q;
        w_cpa_y_d     = r_cpa_y_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_id_d    = r_rsp_id_q;
        w_rsp_sum_d   = r_rsp_sum_q;
        w_rsp_cout_d  = r_rsp_cout_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_any) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (w_gnt_onehot[i]) begin
                            w_cpa_x_d = req_x[i*WIDTH +: WIDTH];
                            w_cpa_y_d = req_y[i*WIDTH +: WIDTH];
                        end
                    end
                    w_grant_id_d = w_gnt_id;
                    w_state_d    = ST_ADD;
                end
            end
            ST_ADD: begin
                w_rsp_sum_d   = cpa_sum;
                w_rsp_cout_d  = cpa_cout;
                w_rsp_id_d    = r_grant_id_q;
                w_rsp_valid_d = 1'b1;
                w_state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_d = 1'b0;
                    w_rr_ptr_d    = (r_grant_id_q == IDW'(NREQ - 1)) ? '0
                                                                     : r_grant_id_q + 1'b1;
                    w_state_d     = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_rr_ptr_q    <= '0;
            r_grant_id_q  <= '0;
            r_cpa_x_q     <= '0;
            r_cpa_y_q     <= '0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_id_q    <= '0;
            r_rsp_sum_q   <= '0;
            r_rsp_cout_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_rr_ptr_q    <= w_rr_ptr_d;
            r_grant_id_q  <= w_grant_id_d;
            r_cpa_x_q     <= w_cpa_x_d;
            r_cpa_y_q     <= w_cpa_y_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_id_q    <= w_rsp_id_d;
            r_rsp_sum_q   <= w_rsp_sum_d;
            r_rsp_cout_q  <= w_rsp_cout_d;
        end
    end

    // Grants only leave the block from IDLE, and never while reset is held.
    assign req_ready = (r_state_q == ST_IDLE && !rst) ? w_gnt_onehot : '0;
    assign cpa_x     = r_cpa_x_q;
    assign cpa_y     = r_cpa_y_q;
    assign rsp_valid = r_rsp_valid_q;
    assign rsp_id    = r_rsp_id_q;
    assign rsp_sum   = r_rsp_sum_q;
    assign rsp_cout  = r_rsp_cout_q;
    assign busy      = (r_state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cpa_share_arb.sv
// ============================================================================
// Module      : tb_cpa_share_arb
// Description : Directed self-checking bench for cpa_share_arb with a CPA model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpa_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_x;
    logic [NREQ*WIDTH-1:0] req_y;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      cpa_x;
    logic [WIDTH-1:0]      cpa_y;
    logic [WIDTH-1:0]      cpa_sum;
    logic                  cpa_cout;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {cpa_cout, cpa_sum} = {1'b0, cpa_x} + {1'b0, cpa_y};

    cpa_share_arb #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .cpa_x     (cpa_x),
        .cpa_y     (cpa_y),
        .cpa_sum   (cpa_sum),
        .cpa_cout  (cpa_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    task automatic set_op(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        req_x[i*WIDTH +: WIDTH] = x;
        req_y[i*WIDTH +: WIDTH] = y;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, cpa_x, cpa_y} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b id=%0d sum=%h cout=%b busy=%b x=%h y=%h, required all 0",
                     req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, cpa_x, cpa_y);
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 4'b0100; set_op(2, 32'd12, 32'd71);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: req_ready=%b required 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0 || cpa_x !== 32'd12 || cpa_y !== 32'd71) begin
            errors++;
            $display("FAIL single_add: rdy=%b busy=%b vld=%b x=%0d y=%0d required 0000 1 0 12 71", req_ready, busy, rsp_valid, cpa_x, cpa_y);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'd83 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: vld=%b id=%0d sum=%0d cout=%b required 1 2 83 0", rsp_valid, rsp_id, rsp_sum, rsp_cout);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: vld=%b busy=%b required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_carry;
        logic [WIDTH-1:0] xs   [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
        logic [WIDTH-1:0] ys   [2] = '{32'h0000_0001, 32'h0000_FFFF};
        logic [WIDTH-1:0] sums [2] = '{32'h0000_0000, 32'h0001_FFFE};
        logic             couts[2] = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            rsp_ready = 1'b1; req_valid = 4'b1000; set_op(3, xs[t], ys[t]);
            #1;
            checks++;
            if (req_ready !== 4'b1000) begin errors++; $display("FAIL carry_grant%0d: req_ready=%b required 1000", t, req_ready); end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== sums[t] || rsp_cout !== couts[t]) begin
                errors++;
                $display("FAIL carry_rsp%0d: vld=%b id=%0d sum=%h cout=%b required 1 3 %h %b",
                         t, rsp_valid, rsp_id, rsp_sum, rsp_cout, sums[t], couts[t]);
            end
        end
    endtask

    task automatic test_round_robin;
        int               order[5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0]  exp_onehot;
        logic [WIDTH-1:0] exp_sum;
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(i), WIDTH'(i + 1));
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_onehot = NREQ'(1) << order[n];
            exp_sum    = WIDTH'(2 * order[n] + 1);
            #1;
            checks++;
            if (req_ready !== exp_onehot) begin errors++; $display("FAIL rr_grant%0d: req_ready=%b required %b", n, req_ready, exp_onehot); end
            @(negedge clk);
            if (n == 4) req_valid = '0;
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_pulse%0d: req_ready=%b required 0000", n, req_ready); end
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(order[n]) || rsp_sum !== exp_sum) begin
                errors++;
                $display("FAIL rr_rsp%0d: vld=%b id=%0d sum=%0d required 1 %0d %0d", n, rsp_valid, rsp_id, rsp_sum, order[n], exp_sum);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0; req_valid = 4'b1010;
        set_op(1, 32'd100, 32'd200); set_op(3, 32'd5, 32'd7);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: req_ready=%b required 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'd300 || rsp_cout !== 1'b0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_stall%0d: vld=%b id=%0d sum=%0d cout=%b rdy=%b required 1 1 300 0 0000",
                         c, rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 4'b1000 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_grant3: req_ready=%b vld=%b required 1000 0", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 32'd12) begin
            errors++;
            $display("FAIL bp_rsp3: vld=%b id=%0d sum=%0d required 1 3 12", rsp_valid, rsp_id, rsp_sum);
        end
        @(negedge clk);
    endtask

    task automatic test_withdrawn;
        req_valid = 4'b0100; set_op(2, 32'd1, 32'd2); set_op(0, 32'd50, 32'd60);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL wd_grant: req_ready=%b required 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_busy_grant: req_ready=%b required 0000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'd3) begin
            errors++;
            $display("FAIL wd_rsp: vld=%b id=%0d sum=%0d required 1 2 3", rsp_valid, rsp_id, rsp_sum);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL wd_idle%0d: vld=%b rdy=%b busy=%b required 0 0000 0", c, rsp_valid, req_ready, busy);
            end
        end
    endtask

    task automatic test_reset_mid_resp;
        rsp_ready = 1'b0; req_valid = 4'b0010; set_op(1, 32'd9, 32'd9);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL mr_grant: req_ready=%b required 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 32'd18) begin
            errors++;
            $display("FAIL mr_rsp: vld=%b sum=%0d required 1 18", rsp_valid, rsp_sum);
        end
        rst = 1'b1; req_valid = 4'b0010;
        @(negedge clk); #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, cpa_x, cpa_y} !== '0) begin
            errors++;
            $display("FAIL mr_in_reset: rdy=%b vld=%b id=%0d sum=%0d busy=%b x=%0d required all 0",
                     req_ready, rsp_valid, rsp_id, rsp_sum, busy, cpa_x);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, cpa_x, cpa_y} !== '0) begin
            errors++;
            $display("FAIL mr_after_reset: rdy=%b vld=%b sum=%0d busy=%b required all 0", req_ready, rsp_valid, rsp_sum, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mr_discard: vld=%b busy=%b required 0 0", rsp_valid, busy);
        end
        // Pointer restarts at 0, so requester 1 beats requester 3.
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL mr_ptr_reset: req_ready=%b required 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_single;
        test_carry;
        test_round_robin;
        test_backpressure;
        test_withdrawn;
        test_reset_mid_resp;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpa_share_arb.md
# cpa_share_arb

Round-robin arbiter and sequencer that time-shares one combinational 32-bit carry-propagate adder (`CPA`: `x`, `y` → `sum`, `cout`) between several requesters, such as Wallace-tree final-stage clients and address/accumulate users. The block:

- accepts operand pairs over per-requester valid/ready handshakes;
- registers the granted operands onto the shared `CPA` inputs;
- captures `sum`/`cout` one cycle later;
- returns the result, tagged with the requester ID, over a single response channel with backpressure.

## Interface

Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `WIDTH`, 32, operand width; must match the `CPA` instance.
- `IDW`, 2, requester ID width; must satisfy `IDW` ≥ ceil(log2(`NREQ`)).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NREQ`: request pending, one bit per requester.
- `req_x` in `NREQ*WIDTH`: operand x; requester i occupies bits [i*`WIDTH` +: `WIDTH`].
- `req_y` in `NREQ*WIDTH`: operand y, same packing as `req_x`.
- `req_ready` out `NREQ`: one-hot grant/accept. Pulses for one cycle.
- `cpa_x` out `WIDTH`: registered operand x to the `CPA`.
- `cpa_y` out `WIDTH`: registered operand y to the `CPA`.
- `cpa_sum` in `WIDTH`: `CPA` sum.
- `cpa_cout` in 1: `CPA` carry-out.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `IDW`: requester index of the response.
- `rsp_sum` out `WIDTH`: captured sum.
- `rsp_cout` out 1: captured carry-out.
- `busy` out 1: state ≠ IDLE.

## Operation

- FSM states: IDLE, ADD, RESP.
- **IDLE:**
  - If any `req_valid` is set, grant the first set bit at or after `rr_ptr`, searching upward modulo `NREQ`.
  - In the same cycle, assert `req_ready[g]` combinationally.
  - On the clock edge, latch `req_x[g]` → `cpa_x`, `req_y[g]` → `cpa_y`, and g → `grant_id`. Go to ADD.
- **ADD:**
  - `CPA` inputs are stable for the full cycle.
  - On the edge, capture `cpa_sum` → `rsp_sum`, `cpa_cout` → `rsp_cout`, `grant_id` → `rsp_id`.
  - Set `rsp_valid`. Go to RESP.
- **RESP:**
  - Hold `rsp_valid` and all `rsp_*` stable until `rsp_ready` = 1 is sampled.
  - On that edge, clear `rsp_valid`, set `rr_ptr` = (`grant_id` + 1) mod `NREQ`, and go to IDLE.
- Round-robin fairness: a requester held valid is granted within `NREQ` transactions.
- Arithmetic: `rsp_sum` = (x + y) mod 2^`WIDTH`; `rsp_cout` = bit `WIDTH` of x + y. Carry-in is always 0.
- Requesters must hold `req_x`/`req_y`/`req_valid` stable until `req_ready` is seen. Deasserting `req_valid` before a grant is legal; the request is simply not granted.
- Reset values:
  - state = IDLE, `rr_ptr` = 0, `grant_id` = 0.
  - `cpa_x` = `cpa_y` = 0.
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_id` = 0.
  - `req_ready` = 0, `busy` = 0.
- `rst` asserted in any state overrides everything: go to IDLE, drop any in-flight result, and issue no `req_ready` in that cycle.

## Timing

- Latency:
  - Grant cycle T (`req_ready` high).
  - `rsp_valid` rises at T+2 (after the edges ending T and T+1).
  - Earliest next grant is the cycle after the `rsp_ready` handshake.
- Throughput: one add per 3 cycles with `rsp_ready` tied high.
- `req_ready` is high only in IDLE and at most one bit at a time.
- `rsp_ready` is ignored outside RESP.
- The `CPA` combinational path (`cpa_x`/`cpa_y` reg → `CPA` → `rsp_sum` reg) is a full-cycle path.

## Structure

- Shared package `cpa_pkg` holds:
  - `CPA_WIDTH` = 32;
  - the FSM state enum (`ST_IDLE` = 2'd0, `ST_ADD` = 2'd1, `ST_RESP` = 2'd2);
  - the `rr_pick` function, or a constant for the max `NREQ`.
- Sub-module `rr_arbiter`, combinational:
  - inputs `req[NREQ]`, `ptr[IDW]`;
  - outputs `gnt_onehot`, `gnt_id`, `any`.
- The `CPA` is instantiated outside this block; the arbiter only drives and samples its ports.

## Test plan

- **Reset:** hold `rst` 2 cycles mid-RESP. Required: all outputs 0, state IDLE, `busy` = 0; the pending response is discarded.
- **Single request:** requester 2, x = 12, y = 71, `rsp_ready` = 1.
  - Required: `req_ready` = 4'b0100 at T.
  - At T+2: `rsp_valid` = 1, `rsp_id` = 2, `rsp_sum` = 83, `rsp_cout` = 0.
- **Carry-out:** x = 32'hFFFFFFFF, y = 32'h00000001. Required: `rsp_sum` = 0, `rsp_cout` = 1. Also check x = y = 16'hFFFF → `rsp_sum` = 32'h0001FFFE, `rsp_cout` = 0.
- **Round-robin:** all 4 requesters held valid, with operands (i, i+1). Required: grant order 0, 1, 2, 3, 0; sums 1, 3, 5, 7; each `req_ready` is a one-cycle pulse.
- **Backpressure:** `rsp_ready` = 0 for 5 cycles while requesters 1 and 3 are valid.
  - Required: `rsp_*` stable across all 5 cycles; no `req_ready` during the stall.
  - After the handshake, the next grant goes to requester 3 (`rr_ptr` = 2 → first valid ≥ 2).
- **Withdrawn request:** requester 0 valid for 1 cycle while the block is busy, then drops. Required: requester 0 is never granted, and no spurious response appears.
